// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
//   Shares one voice datapath among NUM_VOICES voice slots. Each i_SampleStrobe
//   starts a sample period. During the period every slot index is visited once,
//   in ascending order, and each keyed-on slot is issued to the datapath. The
//   signed 24-bit results are summed, and one mixed sample is presented.
//
//   State sequence: IDLE -> ISSUE -> DRAIN -> OUTPUT -> IDLE.
//   A period has a fixed length whatever the key-on mask is. o_MixValid is
//   high exactly NUM_VOICES+PIPE_LATENCY+2 cycles after the strobe cycle.
//
// Ports
//   i_Clock        clock, all logic on the rising edge
//   i_Reset        synchronous, active-high reset
//   i_SampleStrobe one-cycle pulse that starts a sample period
//   i_KeyOnMask    per-slot key-on bits, captured when the strobe is taken
//   o_VoiceValid   issue o_VoiceIndex to the datapath this cycle
//   o_VoiceIndex   slot being issued; holds the last issued slot otherwise
//   i_VoiceValid   datapath result valid
//   i_VoiceSample  datapath result, signed 24-bit
//   o_MixValid     one-cycle pulse when o_MixSample is updated
//   o_MixSample    mixed sample, held until the next o_MixValid
//   o_Busy         a sample period is in progress
//   o_Overrun      sticky flag: a strobe arrived while busy
//   i_ClearStatus  clears o_Overrun; a new overrun in the same cycle wins
//
// Configuration macro
//   VOICE_SCHEDULER_SATURATE_EN : when defined, the accumulator is clamped to
//   the 24-bit signed range when it is reduced to o_MixSample. When undefined,
//   the low 24 bits are kept and the value wraps in two's complement.
// -----------------------------------------------------------------------------
module voice_scheduler #(
   parameter  int NUM_VOICES   = 8,
   parameter  int PIPE_LATENCY = 3,
   parameter  int ACC_WIDTH    = 24 + $clog2(NUM_VOICES) + 1,
   localparam int IDX_W        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_SampleStrobe,
   input  logic [NUM_VOICES-1:0] i_KeyOnMask,
   output logic                  o_VoiceValid,
   output logic [IDX_W-1:0]      o_VoiceIndex,
   input  logic                  i_VoiceValid,
   input  logic signed [23:0]    i_VoiceSample,
   output logic                  o_MixValid,
   output logic [23:0]           o_MixSample,
   output logic                  o_Busy,
   output logic                  o_Overrun,
   input  logic                  i_ClearStatus
);

   localparam int OUT_W = $clog2(NUM_VOICES + 1);
   localparam int DRN_W = $clog2(PIPE_LATENCY + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_OUTPUT = 2'd3;

   logic [1:0]                  state_q,    state_d;
   logic [NUM_VOICES-1:0]       snap_q,     snap_d;
   logic [IDX_W-1:0]            idx_q,      idx_d;
   logic [IDX_W-1:0]            last_idx_q, last_idx_d;
   logic [DRN_W-1:0]            drain_q,    drain_d;
   logic [OUT_W-1:0]            outst_q,    outst_d;
   logic signed [ACC_WIDTH-1:0] acc_q,      acc_d;
   logic [23:0]                 mix_q,      mix_d;
   logic                        overrun_q,  overrun_d;

   logic                        issue;
   logic                        ret;
   logic signed [ACC_WIDTH-1:0] sample_ext;
   logic [23:0]                 mix_reduced;

   assign sample_ext = {{(ACC_WIDTH-24){i_VoiceSample[23]}}, i_VoiceSample};

   // Masked slots still take their cycle in ISSUE. This keeps the issue
   // window the same length for every mask.
   assign issue = (state_q == ST_ISSUE) && snap_q[idx_q];
   // A result that arrives in IDLE belongs to an aborted period, so drop it.
   assign ret   = i_VoiceValid && (state_q != ST_IDLE);

`ifdef VOICE_SCHEDULER_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(8388607);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-8388608);

   always_comb begin
      if (acc_q > SAT_MAX)      mix_reduced = 24'h7F_FFFF;
      else if (acc_q < SAT_MIN) mix_reduced = 24'h80_0000;
      else                      mix_reduced = acc_q[23:0];
   end
`else
   assign mix_reduced = acc_q[23:0];
`endif

   always_comb begin
      // NOTE: every *_d gets its held value first, so paths that do not
      // assign it cannot infer a latch.
      state_d    = state_q;
      snap_d     = snap_q;
      idx_d      = idx_q;
      last_idx_d = issue ? idx_q : last_idx_q;
      drain_d    = drain_q;
      outst_d    = outst_q;
      acc_d      = acc_q;
      mix_d      = mix_q;
      overrun_d  = overrun_q;

      if (ret) acc_d = acc_q + sample_ext;

      // An issue and a return in the same cycle leave the count unchanged.
      case ({issue, ret})
         2'b10:   outst_d = outst_q + OUT_W'(1);
         2'b01:   outst_d = outst_q - OUT_W'(1);
         default: outst_d = outst_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (i_SampleStrobe) begin
               state_d = ST_ISSUE;
               snap_d  = i_KeyOnMask;
               idx_d   = '0;
               acc_d   = '0;
               outst_d = '0;
            end
         end
         ST_ISSUE: begin
            if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DRAIN: begin
            // Wait the full pipeline latency even if nothing is outstanding.
            // This keeps o_MixValid timing independent of the mask.
            if ((drain_q == DRN_W'(PIPE_LATENCY)) && (outst_q == '0)) begin
               state_d = ST_OUTPUT;
               mix_d   = mix_reduced;
            end else if (drain_q != DRN_W'(PIPE_LATENCY)) begin
               drain_d = drain_q + DRN_W'(1);
            end
         end
         ST_OUTPUT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // A strobe in any busy state is dropped. Setting the flag wins over
      // a clear in the same cycle.
      if (i_SampleStrobe && (state_q != ST_IDLE)) overrun_d = 1'b1;
      else if (i_ClearStatus)                     overrun_d = 1'b0;
   end

   // NOTE: every register is reset, including the accumulator and the held
   // mix. This lets a reset in mid-period leave all outputs at zero.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q    <= ST_IDLE;
         snap_q     <= '0;
         idx_q      <= '0;
         last_idx_q <= '0;
         drain_q    <= '0;
         outst_q    <= '0;
         acc_q      <= '0;
         mix_q      <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         idx_q      <= idx_d;
         last_idx_q <= last_idx_d;
         drain_q    <= drain_d;
         outst_q    <= outst_d;
         acc_q      <= acc_d;
         mix_q      <= mix_d;
         overrun_q  <= overrun_d;
      end
   end

   assign o_VoiceValid = issue;
   assign o_VoiceIndex = issue ? idx_q : last_idx_q;
   assign o_MixValid   = (state_q == ST_OUTPUT);
   assign o_MixSample  = mix_q;
   assign o_Busy       = (state_q != ST_IDLE);
   assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_voice_scheduler
//   Table-driven bench for voice_scheduler with NUM_VOICES=4, PIPE_LATENCY=3.
//   A small datapath model returns a per-slot sample from a table. The model
//   answers exactly PIPE_LATENCY cycles after each o_VoiceValid.
//   Cycle 0 is the strobe cycle. Hand-written sequences cover overrun, the
//   priority between set and clear, and reset in mid-period.
// -----------------------------------------------------------------------------
module tb_voice_scheduler;

   localparam int NV = 4;
   localparam int PL = 3;

   logic        clk = 1'b0;
   logic        i_Reset = 1'b1;
   logic        i_SampleStrobe = 1'b0;
   logic [3:0]  i_KeyOnMask = '0;
   logic        o_VoiceValid;
   logic [1:0]  o_VoiceIndex;
   logic        i_VoiceValid = 1'b0;
   logic signed [23:0] i_VoiceSample = '0;
   logic        o_MixValid;
   logic [23:0] o_MixSample;
   logic        o_Busy;
   logic        o_Overrun;
   logic        i_ClearStatus = 1'b0;

   always #5 clk = ~clk;

   voice_scheduler #(.NUM_VOICES(NV), .PIPE_LATENCY(PL)) dut (
      .i_Clock(clk), .i_Reset(i_Reset), .i_SampleStrobe(i_SampleStrobe),
      .i_KeyOnMask(i_KeyOnMask), .o_VoiceValid(o_VoiceValid),
      .o_VoiceIndex(o_VoiceIndex), .i_VoiceValid(i_VoiceValid),
      .i_VoiceSample(i_VoiceSample), .o_MixValid(o_MixValid),
      .o_MixSample(o_MixSample), .o_Busy(o_Busy), .o_Overrun(o_Overrun),
      .i_ClearStatus(i_ClearStatus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Datapath model: a 3-stage delay line of (valid, index).
   logic             pv [1:3] = '{1'b0, 1'b0, 1'b0};
   logic [1:0]       pi [1:3] = '{2'd0, 2'd0, 2'd0};
   logic [3:0][23:0] samp = '0;

   // Advance one cycle. Inputs and samples are taken 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      i_VoiceValid  = pv[3];
      i_VoiceSample = pv[3] ? samp[pi[3]] : 24'd0;
      pv[3] = pv[2]; pi[3] = pi[2];
      pv[2] = pv[1]; pi[2] = pi[1];
      pv[1] = (o_VoiceValid === 1'b1); pi[1] = o_VoiceIndex;
   endtask

   typedef struct {
      logic [3:0]       mask;
      logic [3:0][23:0] s;
      logic [23:0]      mix;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] m, input int a, input int b,
                               input int c, input int d, input int mix);
      vec_t v;
      v.mask = m;
      v.s[0] = 24'(a); v.s[1] = 24'(b); v.s[2] = 24'(c); v.s[3] = 24'(d);
      v.mix  = 24'(mix);
      return v;
   endfunction

   // Run one full period for vector v, starting with a strobe at cycle 0.
   task automatic run_vec(input vec_t v, input string tag);
      int          mv_count = 0;
      int          mv_cycle = -1;
      int          stray    = 0;
      logic [23:0] mix_seen = '0;
      logic [3:0]  vpat     = '0;
      logic [11:0] bpat     = '0;
      samp           = v.s;
      i_KeyOnMask    = v.mask;
      i_SampleStrobe = 1'b1;
      bpat[0]        = o_Busy;
      for (int c = 1; c < 12; c++) begin
         step();
         i_SampleStrobe = 1'b0;
         i_KeyOnMask    = ~v.mask;   // a mask change during the period must be ignored
         bpat[c] = o_Busy;
         if (o_MixValid === 1'b1) begin
            mv_count++; mv_cycle = c; mix_seen = o_MixSample;
         end
         if (c <= 4) begin
            vpat[c-1] = o_VoiceValid;
            if (o_VoiceValid === 1'b1)
               check($sformatf("%s_idx_c%0d", tag, c), 32'(o_VoiceIndex), 32'(c - 1));
         end else if (o_VoiceValid !== 1'b0) begin
            stray++;
         end
      end
      check({tag, "_mixvalid_count"}, 32'(mv_count), 32'd1);
      check({tag, "_mixvalid_cycle"}, 32'(mv_cycle), 32'(NV + PL + 2));
      check({tag, "_mix"},            32'(mix_seen), 32'(v.mix));
      check({tag, "_mix_held"},       32'(o_MixSample), 32'(v.mix));
      check({tag, "_valid_pattern"},  32'(vpat), 32'(v.mask));
      check({tag, "_late_valid"},     32'(stray), 32'd0);
      check({tag, "_busy_pattern"},   32'(bpat), 32'b0011_1111_1110);
   endtask

   vec_t vecs [6];

   initial begin
      int mv_count;
      int mv_cycle;
      logic [23:0] mix_seen;

      vecs[0] = mk(4'b1111, 100, 200, -50, 7, 257);
      vecs[1] = mk(4'b0101, 100, 200, -50, 7, 50);
`ifdef VOICE_SCHEDULER_SATURATE_EN
      vecs[2] = mk(4'b1111, 8388607, 8388607, 8388607, 8388607, 8388607);
      vecs[3] = mk(4'b1111, -8388608, -8388608, -8388608, -8388608, -8388608);
`else
      vecs[2] = mk(4'b1111, 8388607, 8388607, 8388607, 8388607, -4);       // 24'hFFFFFC
      vecs[3] = mk(4'b1111, -8388608, -8388608, -8388608, -8388608, 0);
`endif
      vecs[4] = mk(4'b0000, 11, 22, 33, 44, 0);
      vecs[5] = mk(4'b1010, 1000, -2000, 3000, -4000, -6000);             // 24'hFFE890

      // Reset
      repeat (5) step();
      check("rst_voice_valid", 32'(o_VoiceValid), 32'd0);
      check("rst_voice_index", 32'(o_VoiceIndex), 32'd0);
      check("rst_mix_valid",   32'(o_MixValid),   32'd0);
      check("rst_mix_sample",  32'(o_MixSample),  32'd0);
      check("rst_busy",        32'(o_Busy),       32'd0);
      check("rst_overrun",     32'(o_Overrun),    32'd0);
      i_Reset = 1'b0;
      step();

      // Table-driven periods
      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Overrun: a second strobe 4 cycles after the first.
      samp = vecs[0].s; i_KeyOnMask = vecs[0].mask;
      i_SampleStrobe = 1'b1;
      mv_count = 0; mv_cycle = -1; mix_seen = '0;
      for (int c = 1; c < 17; c++) begin
         step();
         i_SampleStrobe = (c == 4);
         if (c == 4) check("ovr_before", 32'(o_Overrun), 32'd0);
         if (c == 5) check("ovr_set",    32'(o_Overrun), 32'd1);
         if (o_MixValid === 1'b1) begin
            mv_count++; mv_cycle = c; mix_seen = o_MixSample;
         end
      end
      check("ovr_mixvalid_count", 32'(mv_count), 32'd1);
      check("ovr_mixvalid_cycle", 32'(mv_cycle), 32'd9);
      check("ovr_mix",            32'(mix_seen), 32'd257);
      check("ovr_sticky",         32'(o_Overrun), 32'd1);
      i_ClearStatus = 1'b1;
      step();
      i_ClearStatus = 1'b0;
      check("ovr_cleared", 32'(o_Overrun), 32'd0);

      // A set and a clear in the same cycle: the set wins.
      i_SampleStrobe = 1'b1;
      for (int c = 1; c < 12; c++) begin
         step();
         i_SampleStrobe = (c == 3);
         i_ClearStatus  = (c == 3);
         if (c == 4) check("ovr_set_wins", 32'(o_Overrun), 32'd1);
      end
      i_ClearStatus = 1'b1;
      step();
      i_ClearStatus = 1'b0;
      check("ovr_cleared2", 32'(o_Overrun), 32'd0);

      // Reset at cycle 5 of a period. Returns from slots 2 and 3 still arrive at cycles 6 and 7.
      samp = vecs[0].s; i_KeyOnMask = vecs[0].mask;
      i_SampleStrobe = 1'b1;
      mv_count = 0;
      for (int c = 1; c < 16; c++) begin
         step();
         i_SampleStrobe = 1'b0;
         i_Reset = (c == 5);
         if (c == 6) begin
            check("mrst_busy",        32'(o_Busy),       32'd0);
            check("mrst_voice_valid", 32'(o_VoiceValid), 32'd0);
            check("mrst_voice_index", 32'(o_VoiceIndex), 32'd0);
            check("mrst_mix_sample",  32'(o_MixSample),  32'd0);
         end
         if (c >= 6 && o_MixValid === 1'b1) mv_count++;
      end
      check("mrst_no_mixvalid", 32'(mv_count), 32'd0);
      check("mrst_mix_zero",    32'(o_MixSample), 32'd0);
      run_vec(vecs[0], "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
